// File: rtl/rr_arb4.sv
// Round-robin arbiter over N requesters with a per-owner hold limit; registered grant, one-edge latency.
// No backpressure: req is level-sensitive and en low revokes the grant at the next edge.
module rr_arb4 #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_en,
    input  logic [N-1:0]                  i_req,
    output logic [N-1:0]                  o_gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_gnt_id,
    output logic                          o_busy,
    output logic                          o_req_up
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [IW-1:0]   r_last,  w_last_nxt;
    logic [HW-1:0]   r_hold_cnt, w_hold_nxt;

    logic [N-1:0]    w_owner_oh;
    logic [N-1:0]    w_cand;
    logic            w_found;
    logic [IW-1:0]   w_win;

    assign w_owner_oh = {{(N-1){1'b0}}, 1'b1} << r_owner;

    // The owner is masked out while it holds, so a forced rotation can never re-pick it.
    always_comb begin
        w_cand  = (r_state == OWN) ? (i_req & ~w_owner_oh) : i_req;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (int'(r_last) + i) % N;
            if (!w_found && w_cand[IW'(idx)]) begin
                w_found = 1'b1;
                w_win   = IW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold_cnt;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_state_nxt = OWN;
                        w_owner_nxt = w_win;
                        w_last_nxt  = w_win;
                        w_hold_nxt  = HW'(1);
                    end
                end
                OWN: begin
                    if (!i_req[r_owner]) begin
                        if (w_found) begin
                            w_owner_nxt = w_win;
                            w_last_nxt  = w_win;
                            w_hold_nxt  = HW'(1);
                        end else begin
                            w_state_nxt = IDLE;
                            w_hold_nxt  = '0;
                        end
                    end else if (r_hold_cnt < HW'(MAX_HOLD)) begin
                        w_hold_nxt = r_hold_cnt + HW'(1);
                    end else begin
                        // Limit reached: rotate if anyone else waits, otherwise restart the hold window.
                        if (w_found) begin
                            w_owner_nxt = w_win;
                            w_last_nxt  = w_win;
                        end
                        w_hold_nxt = HW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_last     <= IW'(N - 1);
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign o_busy   = (r_state == OWN);
    assign o_gnt    = o_busy ? w_owner_oh : '0;
    assign o_gnt_id = o_busy ? r_owner : '0;
    assign o_req_up = |i_req;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4: stimulus pushes expected {gnt,gnt_id,busy,req_up}; a monitor pops after each edge.
module tb_rr_arb4;
    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       req_up;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } exp_t;
    exp_t q[$];

    rr_arb4 #(.N(4), .MAX_HOLD(4)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_en    (en),
        .i_req   (req),
        .o_gnt   (gnt),
        .o_gnt_id(gnt_id),
        .o_busy  (busy),
        .o_req_up(req_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got gnt/id/busy/up=%b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change at the negedge; the matching expectation is checked just after the following posedge.
    task automatic drive(input string nm, input logic [3:0] r, input logic e,
                         input logic [3:0] g, input logic [1:0] id, input logic b);
        exp_t x;
        req  = r;
        en   = e;
        x.nm = nm;
        x.v  = {g, id, b, |r};
        q.push_back(x);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk(x.nm, {gnt, gnt_id, busy, req_up}, x.v);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        en  = 1'b1;
        req = 4'b1111;
        #2;
        chk("reset_outputs", {gnt, gnt_id, busy, req_up}, 8'b0000_00_0_1);
        @(negedge clk);
        @(negedge clk);
        chk("reset_held_over_edges", {gnt, gnt_id, busy, req_up}, 8'b0000_00_0_1);
        rst = 1'b0;

        // Continuous 1111: four cycles per owner, then wrap to 0.
        for (int k = 0; k < 17; k++) begin
            logic [3:0] g;
            logic [1:0] id;
            id = 2'((k / 4) % 4);
            g  = 4'b0001 << id;
            drive("rotation", 4'b1111, 1'b1, g, id, 1'b1);
        end

        // Owner 0 drops; only 2 waits. Then owner 2 drops with 1011 pending: search from 3 hits 3.
        drive("handoff_to_2", 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1);
        drive("handoff_to_3", 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1);
        drive("release_idle", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);

        // Sole requester keeps the grant across the hold limit without a bubble.
        for (int k = 0; k < 10; k++)
            drive("sole_req1", 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1);

        drive("owner0", 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        drive("en_low_a", 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0);
        drive("en_low_b", 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0);
        drive("en_back",  4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);

        drive("owner3", 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1);
        #2;
        req = 4'b1001;
        rst = 1'b1;
        #1;
        chk("async_reset_midgrant", {gnt, gnt_id, busy, req_up}, 8'b0000_00_0_1);
        @(negedge clk);
        rst = 1'b0;
        drive("post_reset_prio0", 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1);
        // Owner 0 drops while 3 waits: owner is never re-granted on the edge it drops.
        drive("drop_owner_to_3", 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1);

        begin
            int waited;
            waited = 0;
            while (q.size() > 0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            if (q.size() > 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL drain: %0d expectations left, expected 0", q.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/rr_arb4.md
# rr_arb4

Registered round-robin arbiter with bounded grant hold. It shares one downstream resource (bus port, functional unit, memory port) between N requesters. Rotating priority guarantees fairness, and a per-grant hold limit prevents one requester from monopolising the resource. It sits in front of the shared resource and replaces fixed-priority selection wherever starvation is unacceptable.

## Interface
- N, 4, number of requesters (legal 2..16)
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while others wait (legal >= 1)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  arbitration enable; low revokes any grant at the next edge
- req  input  N  request vector, one bit per requester, level-sensitive
- gnt  output  N  registered grant, one-hot or all-zero
- gnt_id  output  $clog2(N)  index of the granted requester; 0 when gnt is zero
- busy  output  1  registered; high exactly when gnt is nonzero
- req_up  output  1  combinational OR of req, independent of en and state

## Operation
- State: IDLE (no owner) or OWN (one owner).
- Internal registers:
  - owner: index of the current grant holder.
  - hold_cnt: cycles the current owner has been granted, range 1..MAX_HOLD.
  - last: index most recently granted; this is the priority pointer.
- Winner search: scan indices last+1, last+2, … modulo N. The first asserted req bit wins. last itself is checked last.
- "Others pending" means req with the owner bit masked off is nonzero.
- Per-edge behaviour, first matching rule applies:
  - en=0: go to IDLE, gnt=0, hold_cnt=0; last is unchanged.
  - IDLE, en=1, req=0: stay in IDLE.
  - IDLE, en=1, req!=0: grant winner w; go to OWN; owner=w, last=w, hold_cnt=1.
  - OWN, req[owner]=0, others pending: grant winner w from the search (zero-bubble handoff); owner=w, last=w, hold_cnt=1.
  - OWN, req[owner]=0, no others pending: go to IDLE, gnt=0.
  - OWN, req[owner]=1, hold_cnt<MAX_HOLD: keep the grant; hold_cnt+1.
  - OWN, req[owner]=1, hold_cnt=MAX_HOLD, others pending: forced rotation to winner w (never the owner, because the owner bit is masked); hold_cnt=1.
  - OWN, req[owner]=1, hold_cnt=MAX_HOLD, no others pending: keep the grant; hold_cnt=1 with no bubble.
- With MAX_HOLD=1, every cycle with other requests pending rotates the grant.
- gnt, gnt_id and busy derive from the same registered state and are always mutually consistent.

## Timing
- Reset, asynchronous with immediate effect:
  - State IDLE, gnt=0, gnt_id=0, busy=0, hold_cnt=0.
  - last=N-1, so requester 0 has highest priority first.
  - req_up still follows req during reset.
- Latency: a req sampled at edge k produces gnt at edge k (registered output, visible in cycle k+1).
- Release: the owner drops req in cycle t → gnt moves or clears at the next edge. The resource may see a grant to a non-requesting owner for at most the one cycle in which it dropped req.
- Worst-case wait for a continuously requesting index: (N-1)·MAX_HOLD cycles after its request is first sampled with en=1.
- en is sampled only at edges; en toggling mid-hold restarts arbitration from last+1.
- Reset asserted mid-grant clears gnt asynchronously. The first post-reset grant follows the reset priority (index 0 first).
- A requester that drops req is never granted on that edge, even if it has rotation priority.

## Test plan
- Reset/first grant: assert reset, then release it with req=4'b1111 and en=1 → after one edge gnt=0001, gnt_id=0, busy=1. All outputs are 0 during reset while req_up=1.
- Rotation with MAX_HOLD=4: hold req=1111 → gnt stays 0001 for 4 cycles, then 0010 for 4, then 0100 for 4, then 1000 for 4, then wraps to 0001.
- Release handoff: owner 2 (gnt=0100) drops req while req=1011 → next edge gnt=1000 (the search from index 3 finds index 3 first). Then req=0000 → gnt=0000, busy=0.
- Sole requester past the limit: only req[1]=1 for 10 cycles → gnt=0010 every cycle with no bubble; hold_cnt wraps 4→1.
- en revocation: owner 0 holding, en dropped for 2 cycles with req=0011 → gnt=0000 after one edge. With en=1 again → gnt=0010, because last=0 is preserved.
- Asynchronous reset mid-grant: pulse reset between edges while gnt=1000 → gnt=0 immediately without waiting for a clock edge. After release with req=1001 → gnt=0001.
